// File: rtl/branch_pkg.sv
// Shared branch types: funct3 condition codes, 2-bit predictor states, PC step.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  localparam int PC_STEP = 4;

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic bht_state_e bht_next(input bht_state_e s, input logic taken);
    if (taken) return (s == ST)  ? ST  : bht_state_e'(s + 2'd1);
    else       return (s == SNT) ? SNT : bht_state_e'(s - 2'd1);
  endfunction

endpackage

// File: rtl/branch_history_table.sv
// Direct-mapped table of 2-bit saturating counters indexed by word PC bits.
// Lookup is combinational; an update lands on the clock edge, so a lookup of
// the same index in the update cycle still sees the old counter.
module branch_history_table
  import branch_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] BHT_INIT    = 2'b01
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
  output logic                  pred_taken_o,
  input  logic                  upd_en_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_taken_i
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  if (BHT_ENTRIES < 2 || (BHT_ENTRIES & (BHT_ENTRIES - 1)) != 0) begin : g_bad_depth
    $error("BHT_ENTRIES must be a power of 2 and at least 2");
  end

  logic [1:0]       tbl [BHT_ENTRIES];
  logic [IDX_W-1:0] lkp_idx, upd_idx;

  assign lkp_idx = lookup_pc_i[IDX_W+1:2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];

  // Byte-offset and high PC bits do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], lookup_pc_i[ADDR_WIDTH-1:IDX_W+2],
                            upd_pc_i[1:0], upd_pc_i[ADDR_WIDTH-1:IDX_W+2]};

  // Counter table: reset every entry, train the indexed entry on update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_ENTRIES; i++) tbl[i] <= BHT_INIT;
    end else if (upd_en_i) begin
      tbl[upd_idx] <= bht_next(bht_state_e'(tbl[upd_idx]), upd_taken_i);
    end
  end

  assign pred_taken_o = tbl[lkp_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolve-stage branch unit: evaluates the condition, flags mispredicts with a
// corrected fetch target, trains the BHT and counts mispredicts.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int         DATA_WIDTH  = 32,
  parameter int         ADDR_WIDTH  = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] BHT_INIT    = 2'b01
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] FetchPC_i,
  output logic                  PredTaken_o,
  input  logic                  Valid_i,
  input  logic                  Branch_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] Rs1_i,
  input  logic [DATA_WIDTH-1:0] Rs2_i,
  input  logic [ADDR_WIDTH-1:0] PC_i,
  input  logic [ADDR_WIDTH-1:0] Imm_i,
  input  logic                  PredTaken_i,
  input  logic                  Stall_i,
  output logic                  ResolveValid_o,
  output logic                  BranchTaken_o,
  output logic                  Redirect_o,
  output logic [ADDR_WIDTH-1:0] RedirectPC_o,
  output logic                  IllegalBranch_o,
  output logic [31:0]           MispredictCount_o
);

  logic                  shadow, accept, taken, illegal, mispredict;
  logic [ADDR_WIDTH-1:0] target;

  // The cycle carrying Redirect_o holds a wrong-path instruction; squash it.
  assign shadow = Redirect_o;
  assign accept = Valid_i & Branch_i & ~Stall_i & ~shadow;

  // Condition evaluation; reserved funct3 codes resolve not-taken.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (br_op_e'(funct3_i))
      BR_BEQ:  taken = (Rs1_i == Rs2_i);
      BR_BNE:  taken = (Rs1_i != Rs2_i);
      BR_BLT:  taken = ($signed(Rs1_i) <  $signed(Rs2_i));
      BR_BGE:  taken = ($signed(Rs1_i) >= $signed(Rs2_i));
      BR_BLTU: taken = (Rs1_i <  Rs2_i);
      BR_BGEU: taken = (Rs1_i >= Rs2_i);
      default: illegal = 1'b1;
    endcase
  end

  assign mispredict = taken ^ PredTaken_i;
  assign target     = taken ? (PC_i + Imm_i) : (PC_i + ADDR_WIDTH'(PC_STEP));

  // Registered resolve results: pulses for one cycle per accepted branch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ResolveValid_o  <= 1'b0;
      BranchTaken_o   <= 1'b0;
      Redirect_o      <= 1'b0;
      IllegalBranch_o <= 1'b0;
      RedirectPC_o    <= '0;
    end else begin
      ResolveValid_o  <= accept;
      BranchTaken_o   <= accept & taken;
      Redirect_o      <= accept & mispredict;
      IllegalBranch_o <= accept & illegal;
      if (accept && mispredict) RedirectPC_o <= target;
    end
  end

  // Saturating mispredict counter, stepped on the edge that raises Redirect_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                          MispredictCount_o <= '0;
    else if (accept && mispredict && MispredictCount_o != '1) MispredictCount_o <= MispredictCount_o + 32'd1;
  end

  branch_history_table #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BHT_ENTRIES (BHT_ENTRIES),
    .BHT_INIT    (BHT_INIT)
  ) u_bht (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .lookup_pc_i  (FetchPC_i),
    .pred_taken_o (PredTaken_o),
    .upd_en_i     (accept & ~illegal),
    .upd_pc_i     (PC_i),
    .upd_taken_i  (taken)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: one task per scenario.
module tb_branch_resolve_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] FetchPC_i = '0;
  logic        PredTaken_o;
  logic        Valid_i = 1'b0, Branch_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] Rs1_i = '0, Rs2_i = '0, PC_i = '0, Imm_i = '0;
  logic        PredTaken_i = 1'b0, Stall_i = 1'b0;
  logic        ResolveValid_o, BranchTaken_o, Redirect_o, IllegalBranch_o;
  logic [31:0] RedirectPC_o, MispredictCount_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  branch_resolve_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .FetchPC_i(FetchPC_i), .PredTaken_o(PredTaken_o),
    .Valid_i(Valid_i), .Branch_i(Branch_i), .funct3_i(funct3_i), .Rs1_i(Rs1_i),
    .Rs2_i(Rs2_i), .PC_i(PC_i), .Imm_i(Imm_i), .PredTaken_i(PredTaken_i),
    .Stall_i(Stall_i), .ResolveValid_o(ResolveValid_o), .BranchTaken_o(BranchTaken_o),
    .Redirect_o(Redirect_o), .RedirectPC_o(RedirectPC_o),
    .IllegalBranch_o(IllegalBranch_o), .MispredictCount_o(MispredictCount_o)
  );

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pt);
    Valid_i = 1'b1; Branch_i = 1'b1; funct3_i = f3;
    Rs1_i = a; Rs2_i = b; PC_i = pc; Imm_i = imm; PredTaken_i = pt;
  endtask

  task automatic idle();
    Valid_i = 1'b0; Branch_i = 1'b0; Stall_i = 1'b0;
  endtask

  // Outputs grouped so one comparison covers a whole resolve result.
  function automatic logic [3:0] pulses();
    return {ResolveValid_o, BranchTaken_o, Redirect_o, IllegalBranch_o};
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0; FetchPC_i = 32'h40;
    cyc(); cyc();
    n_tests++; if (PredTaken_o !== 1'b0) begin n_fail++; $display("FAIL reset_pred got=%b exp=0", PredTaken_o); end
    n_tests++; if (pulses() !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=0000", pulses()); end
    n_tests++; if (RedirectPC_o !== 32'h0) begin n_fail++; $display("FAIL reset_rpc got=%h exp=0", RedirectPC_o); end
    n_tests++; if (MispredictCount_o !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", MispredictCount_o); end
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_blt_bltu();
    drive(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    cyc(); idle();
    n_tests++; if (pulses() !== 4'b1110) begin n_fail++; $display("FAIL blt_pulses got=%b exp=1110", pulses()); end
    n_tests++; if (RedirectPC_o !== 32'h120) begin n_fail++; $display("FAIL blt_rpc got=%h exp=120", RedirectPC_o); end
    n_tests++; if (MispredictCount_o !== 32'd1) begin n_fail++; $display("FAIL blt_cnt got=%0d exp=1", MispredictCount_o); end
    cyc();
    n_tests++; if (Redirect_o !== 1'b0) begin n_fail++; $display("FAIL blt_redirect_drop got=%b exp=0", Redirect_o); end
    drive(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
    cyc(); idle();
    n_tests++; if (pulses() !== 4'b1000) begin n_fail++; $display("FAIL bltu_pulses got=%b exp=1000", pulses()); end
    n_tests++; if (RedirectPC_o !== 32'h120) begin n_fail++; $display("FAIL bltu_rpc_hold got=%h exp=120", RedirectPC_o); end
    n_tests++; if (MispredictCount_o !== 32'd1) begin n_fail++; $display("FAIL bltu_cnt got=%0d exp=1", MispredictCount_o); end
    cyc();
  endtask

  // Index 0 is back at 01 after the BLT(+1)/BLTU(-1) pair above.
  task automatic test_bht_train();
    logic exp_pred [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    FetchPC_i = 32'h200;
    drive(3'b000, 32'd5, 32'd5, 32'h200, 32'h40, 1'b1);
    n_tests++; if (PredTaken_o !== 1'b0) begin n_fail++; $display("FAIL train_pre got=%b exp=0", PredTaken_o); end
    for (int i = 0; i < 5; i++) begin
      if (i >= 3) drive(3'b000, 32'd5, 32'd6, 32'h200, 32'h40, 1'b0);
      cyc();
      n_tests++; if (PredTaken_o !== exp_pred[i]) begin n_fail++; $display("FAIL train_pred[%0d] got=%b exp=%b", i, PredTaken_o, exp_pred[i]); end
      n_tests++; if ({ResolveValid_o, Redirect_o} !== 2'b10) begin n_fail++; $display("FAIL train_valid[%0d] got=%b exp=10", i, {ResolveValid_o, Redirect_o}); end
    end
    idle(); cyc();
    n_tests++; if (MispredictCount_o !== 32'd1) begin n_fail++; $display("FAIL train_cnt got=%0d exp=1", MispredictCount_o); end
  endtask

  task automatic test_shadow();
    drive(3'b001, 32'd1, 32'd2, 32'h104, 32'h10, 1'b0);
    cyc();
    n_tests++; if (pulses() !== 4'b1110) begin n_fail++; $display("FAIL shadow_first got=%b exp=1110", pulses()); end
    n_tests++; if (RedirectPC_o !== 32'h114) begin n_fail++; $display("FAIL shadow_rpc got=%h exp=114", RedirectPC_o); end
    drive(3'b000, 32'd7, 32'd7, 32'h208, 32'h80, 1'b0);
    cyc(); idle();
    n_tests++; if (pulses() !== 4'b0000) begin n_fail++; $display("FAIL shadow_squash got=%b exp=0000", pulses()); end
    n_tests++; if (RedirectPC_o !== 32'h114) begin n_fail++; $display("FAIL shadow_rpc_hold got=%h exp=114", RedirectPC_o); end
    n_tests++; if (MispredictCount_o !== 32'd2) begin n_fail++; $display("FAIL shadow_cnt got=%0d exp=2", MispredictCount_o); end
    FetchPC_i = 32'h208; #1;
    n_tests++; if (PredTaken_o !== 1'b0) begin n_fail++; $display("FAIL shadow_bht got=%b exp=0", PredTaken_o); end
    FetchPC_i = 32'h104; #1;
    n_tests++; if (PredTaken_o !== 1'b1) begin n_fail++; $display("FAIL shadow_first_bht got=%b exp=1", PredTaken_o); end
    cyc();
  endtask

  // Entry for 0x104 is 10, so any not-taken training would clear the MSB.
  task automatic test_illegal_stall();
    FetchPC_i = 32'h104;
    drive(3'b010, 32'd3, 32'd3, 32'h104, 32'h10, 1'b0);
    cyc(); idle();
    n_tests++; if (pulses() !== 4'b1001) begin n_fail++; $display("FAIL illegal_pulses got=%b exp=1001", pulses()); end
    n_tests++; if (PredTaken_o !== 1'b1) begin n_fail++; $display("FAIL illegal_bht got=%b exp=1", PredTaken_o); end
    cyc();
    drive(3'b001, 32'd3, 32'd3, 32'h104, 32'h10, 1'b1);
    Stall_i = 1'b1;
    cyc(); cyc(); idle();
    n_tests++; if (pulses() !== 4'b0000) begin n_fail++; $display("FAIL stall_pulses got=%b exp=0000", pulses()); end
    n_tests++; if (PredTaken_o !== 1'b1) begin n_fail++; $display("FAIL stall_bht got=%b exp=1", PredTaken_o); end
    n_tests++; if (MispredictCount_o !== 32'd2) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=2", MispredictCount_o); end
    cyc();
  endtask

  task automatic test_wrap_and_reset();
    drive(3'b000, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h8, 1'b0);
    cyc(); idle();
    n_tests++; if (pulses() !== 4'b1110) begin n_fail++; $display("FAIL wrap_pulses got=%b exp=1110", pulses()); end
    n_tests++; if (RedirectPC_o !== 32'h4) begin n_fail++; $display("FAIL wrap_rpc got=%h exp=4", RedirectPC_o); end
    n_tests++; if (MispredictCount_o !== 32'd3) begin n_fail++; $display("FAIL wrap_cnt got=%0d exp=3", MispredictCount_o); end
    // Asynchronous assertion clears outputs without waiting for an edge.
    #2 rst_ni = 1'b0; #1;
    n_tests++; if (Redirect_o !== 1'b0) begin n_fail++; $display("FAIL async_rst got=%b exp=0", Redirect_o); end
    rst_ni = 1'b1;
    cyc(); cyc();
    // Event in flight when reset drops must never produce a redirect.
    drive(3'b000, 32'd1, 32'd1, 32'h300, 32'h40, 1'b0);
    #2 rst_ni = 1'b0;
    cyc(); idle();
    n_tests++; if (pulses() !== 4'b0000) begin n_fail++; $display("FAIL rst_inflight got=%b exp=0000", pulses()); end
    #2 rst_ni = 1'b1;
    cyc();
    n_tests++; if (Redirect_o !== 1'b0) begin n_fail++; $display("FAIL rst_release got=%b exp=0", Redirect_o); end
    n_tests++; if (MispredictCount_o !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", MispredictCount_o); end
    n_tests++; if (RedirectPC_o !== 32'd0) begin n_fail++; $display("FAIL rst_rpc got=%h exp=0", RedirectPC_o); end
    FetchPC_i = 32'h104; #1;
    n_tests++; if (PredTaken_o !== 1'b0) begin n_fail++; $display("FAIL rst_bht got=%b exp=0", PredTaken_o); end
  endtask

  initial begin
    test_reset();
    test_blt_bltu();
    test_bht_train();
    test_shadow();
    test_illegal_stall();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the operand width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, the PC/immediate width.
REQ-003 The block SHALL have parameter BHT_ENTRIES, default 64, the branch history table depth; it must be a power of 2 and at least 2.
REQ-004 The block SHALL have parameter BHT_INIT, default 2'b01, the reset state of every counter.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port FetchPC_i, input, ADDR_WIDTH bits: the fetch-stage PC used for the prediction lookup.
REQ-008 The block SHALL have port PredTaken_o, output, 1 bit: the combinational prediction for FetchPC_i.
REQ-009 The block SHALL have port Valid_i, input, 1 bit: an instruction is present at resolve.
REQ-010 The block SHALL have port Branch_i, input, 1 bit: the instruction is a conditional branch.
REQ-011 The block SHALL have port funct3_i, input, 3 bits: the branch condition code.
REQ-012 The block SHALL have port Rs1_i, input, DATA_WIDTH bits: the first operand.
REQ-013 The block SHALL have port Rs2_i, input, DATA_WIDTH bits: the second operand.
REQ-014 The block SHALL have port PC_i, input, ADDR_WIDTH bits: the branch instruction PC.
REQ-015 The block SHALL have port Imm_i, input, ADDR_WIDTH bits: the sign-extended branch offset.
REQ-016 The block SHALL have port PredTaken_i, input, 1 bit: the prediction carried down the pipeline with the instruction.
REQ-017 The block SHALL have port Stall_i, input, 1 bit: the resolve stage is stalled.
REQ-018 The block SHALL have port ResolveValid_o, output, 1 bit: a registered pulse marking one resolved branch.
REQ-019 The block SHALL have port BranchTaken_o, output, 1 bit: the registered actual outcome.
REQ-020 The block SHALL have port Redirect_o, output, 1 bit: a registered mispredict pulse.
REQ-021 The block SHALL have port RedirectPC_o, output, ADDR_WIDTH bits: the registered corrected fetch target.
REQ-022 The block SHALL have port IllegalBranch_o, output, 1 bit: a registered pulse for an illegal funct3.
REQ-023 The block SHALL have port MispredictCount_o, output, 32 bits: a saturating count of mispredicts.

Function
REQ-024 An accepted event SHALL be Valid_i & Branch_i & !Stall_i & !shadow; Valid_i with Branch_i=0 has no effect.
REQ-025 The outcome SHALL be computed from funct3: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
REQ-026 For funct3 010 or 011, the event SHALL resolve as not-taken, pulse IllegalBranch_o, and leave the BHT unchanged.
REQ-027 All resolve outputs SHALL be registered: they are valid exactly 1 cycle after an accepted event, and the pulses are 0 in every other cycle.
REQ-028 A mispredict SHALL occur when the outcome differs from PredTaken_i; Redirect_o=1 and RedirectPC_o = taken ? PC_i+Imm_i : PC_i+4, computed modulo 2^ADDR_WIDTH.
REQ-029 RedirectPC_o SHALL hold its last value while Redirect_o=0.
REQ-030 The shadow flag SHALL be 1 in exactly the cycle in which Redirect_o=1; any Valid_i in that cycle is a wrong-path instruction and is discarded.
REQ-031 While Stall_i=1, the block SHALL produce no event, make no BHT update, and hold the counter.
REQ-032 The BHT index SHALL be PC[log2(BHT_ENTRIES)+1:2]; each entry is a 2-bit saturating counter (taken: +1, saturating at 11; not-taken: -1, saturating at 00).
REQ-033 PredTaken_o SHALL be the MSB of the entry at FetchPC_i's index; it is combinational, with no added latency.
REQ-034 The BHT update SHALL occur on the edge that accepts the event; a same-cycle lookup of the same index returns the pre-update value.
REQ-035 MispredictCount_o SHALL increment on each edge that sets Redirect_o and saturate at 0xFFFFFFFF.

Reset
REQ-036 While rst_ni=0, all outputs, shadow and the counter SHALL be 0, and all BHT entries SHALL equal BHT_INIT; an event in flight is discarded with no Redirect_o.
REQ-037 Reset assertion SHALL be asynchronous, and release SHALL take effect at the next clk_i rising edge.

Structure
REQ-038 The shared package branch_pkg SHALL hold the br_op_e funct3 enum, bht_state_e (SNT=00, WNT=01, WT=10, ST=11), and the PC_STEP=4 constant.
REQ-039 The counter table, lookup and update SHALL be the sub-module branch_history_table; condition and redirect logic stay in the top level.

Verification
REQ-040 The bench SHALL cover: reset, then FetchPC_i=0x40 -> PredTaken_o=0, and all outputs and MispredictCount_o = 0.
REQ-041 The bench SHALL cover: BLT with Rs1=0xFFFFFFFF, Rs2=1, PC=0x100, Imm=0x20, PredTaken_i=0 -> next cycle BranchTaken_o=1, Redirect_o=1, RedirectPC_o=0x120, count=1; then BLTU with the same operands -> not taken, no redirect.
REQ-042 The bench SHALL cover: three taken BEQ at PC 0x200 -> entry 01->10->11->11, and PredTaken_o(0x200)=1 after the first; then two not-taken -> 10->01, PredTaken_o=0.
REQ-043 The bench SHALL cover: a mispredict followed by Valid_i/Branch_i in the Redirect_o cycle -> no ResolveValid_o and no BHT change for the second branch.
REQ-044 The bench SHALL cover: funct3=010 -> IllegalBranch_o=1 with BHT unchanged; and Stall_i=1 with a valid branch -> all pulses 0 with no update.
REQ-045 The bench SHALL cover: PC=0xFFFFFFFC, Imm=8, taken, PredTaken_i=0 -> RedirectPC_o=0x4; and rst_ni low in the cycle after the event -> Redirect_o stays 0.
